// File: rtl/player_input_ctrl.sv
// Per-player button conditioning and choice handshake; optional AUTO_REPEAT_EN macro
// enables hold-to-repeat selection stepping.
module pid_debounce #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic pulse
);
    localparam int CW = $clog2(CYCLES) + 1;

    logic [CW-1:0] cnt;
    logic          s1;
    logic          s2;
    logic          prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            prev  <= 1'b0;
            pulse <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            prev  <= level;
            pulse <= level & ~prev;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module player_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_CHOICES     = 4,
    parameter int SEL_W           = 2,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sel_btn,
    input  logic             conf_btn,
    output logic [SEL_W-1:0] choice,
    output logic             choice_valid,
    input  logic             choice_ready,
    output logic             sel_pulse,
    output logic             conf_pulse
);
    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        OFFER
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [SEL_W-1:0] choice_n;
    logic             sel_db_pulse;
    logic             sel_ev;

`ifdef AUTO_REPEAT_EN
    logic sel_level;
`endif

    pid_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sel_btn),
`ifdef AUTO_REPEAT_EN
        .level (sel_level),
`else
        .level (),
`endif
        .pulse (sel_db_pulse)
    );

    pid_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_conf (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (conf_btn),
        .level (),
        .pulse (conf_pulse)
    );

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES) + 1;

    logic [RW-1:0] rep_cnt;
    logic          rep_hit;

    // Repeat steps are timed from the press pulse and from each previous step.
    assign rep_hit = (state == SELECT) && sel_level && !sel_db_pulse &&
                     (rep_cnt == RW'(REPEAT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || state != SELECT || state_n != SELECT ||
            !sel_level || sel_db_pulse || rep_hit) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end

    assign sel_ev = sel_db_pulse | rep_hit;
`else
    assign sel_ev = sel_db_pulse;
`endif

    assign sel_pulse    = sel_ev;
    assign choice_valid = (state == OFFER);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            choice <= '0;
        end else begin
            state  <= state_n;
            choice <= choice_n;
        end
    end

    always_comb begin
        state_n  = state;
        choice_n = choice;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_n  = SELECT;
                    choice_n = '0;
                end
            end
            SELECT: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (conf_pulse) begin
                    state_n = OFFER;
                end else if (sel_ev) begin
                    if (choice == SEL_W'(NUM_CHOICES - 1)) begin
                        choice_n = '0;
                    end else begin
                        choice_n = choice + 1'b1;
                    end
                end
            end
            OFFER: begin
                if (choice_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl: vector table plus multi-cycle corner sequences.
module tb_player_input_ctrl;
    localparam int D = 16;
    localparam int R = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       sel_btn = 1'b0;
    logic       conf_btn = 1'b0;
    logic       choice_ready = 1'b0;
    logic [1:0] choice;
    logic       choice_valid;
    logic       sel_pulse;
    logic       conf_pulse;

    int checks = 0;
    int errors = 0;
    int sel_cnt = 0;
    int conf_cnt = 0;

    player_input_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .NUM_CHOICES(4),
        .SEL_W(2),
        .REPEAT_CYCLES(R)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .sel_btn(sel_btn),
        .conf_btn(conf_btn),
        .choice(choice),
        .choice_valid(choice_valid),
        .choice_ready(choice_ready),
        .sel_pulse(sel_pulse),
        .conf_pulse(conf_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sel_pulse) sel_cnt++;
        if (conf_pulse) conf_cnt++;
    end

    typedef struct {
        int         op;
        logic       en;
        logic       rdy;
        logic [1:0] exp_choice;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // op 0: idle, 1: sel press, 2: conf press, 3: both together
    task automatic press(input int op);
        if (op == 0) begin
            tick(12);
        end else begin
            sel_btn  = (op == 1 || op == 3);
            conf_btn = (op == 2 || op == 3);
            tick(D + 8);
            sel_btn  = 1'b0;
            conf_btn = 1'b0;
            tick(D + 8);
        end
    endtask

    initial begin
        int first;
        int exp_rep;

        vecs[0]  = '{1, 1'b1, 1'b0, 2'd1, 1'b0};
        vecs[1]  = '{1, 1'b1, 1'b0, 2'd2, 1'b0};
        vecs[2]  = '{1, 1'b1, 1'b0, 2'd3, 1'b0};
        vecs[3]  = '{1, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[4]  = '{1, 1'b1, 1'b0, 2'd1, 1'b0};
        vecs[5]  = '{2, 1'b1, 1'b0, 2'd1, 1'b1};
        vecs[6]  = '{1, 1'b1, 1'b0, 2'd1, 1'b1};
        vecs[7]  = '{2, 1'b1, 1'b0, 2'd1, 1'b1};
        vecs[8]  = '{0, 1'b1, 1'b1, 2'd0, 1'b0};
        vecs[9]  = '{1, 1'b1, 1'b0, 2'd1, 1'b0};
        vecs[10] = '{1, 1'b1, 1'b0, 2'd2, 1'b0};
        vecs[11] = '{3, 1'b1, 1'b0, 2'd2, 1'b1};
        vecs[12] = '{0, 1'b0, 1'b0, 2'd2, 1'b1};

        tick(3);
        chk("reset_choice", choice, 0);
        chk("reset_valid", choice_valid, 0);
        chk("reset_sel_pulse", sel_pulse, 0);
        chk("reset_conf_pulse", conf_pulse, 0);
        rst_n = 1'b1;
        tick(2);

        sel_cnt = 0;
        sel_btn = 1'b1;
        tick(10);
        sel_btn = 1'b0;
        tick(30);
        chk("glitch_no_pulse", sel_cnt, 0);

        first = 0;
        sel_cnt = 0;
        sel_btn = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (sel_pulse && first == 0) first = n;
        end
        sel_btn = 1'b0;
        tick(30);
        chk("press_latency", first, D + 3);
        chk("press_one_pulse", sel_cnt, 1);
        chk("idle_choice_hold", choice, 0);

        en = 1'b1;
        tick(2);
        chk("select_entry", choice, 0);

        for (int i = 0; i < 13; i++) begin
            en = vecs[i].en;
            choice_ready = vecs[i].rdy;
            press(vecs[i].op);
            chk($sformatf("vec%0d_choice", i), choice, vecs[i].exp_choice);
            chk($sformatf("vec%0d_valid", i), choice_valid, vecs[i].exp_valid);
        end

        choice_ready = 1'b1;
        tick(1);
        chk("accept_valid_drop", choice_valid, 0);
        chk("accept_choice_hold", choice, 2);
        choice_ready = 1'b0;

        en = 1'b1;
        tick(2);
        conf_cnt = 0;
        press(2);
        chk("offer_before_rst", choice_valid, 1);
        chk("offer_conf_count", conf_cnt, 1);
        rst_n = 1'b0;
        en = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("rst_mid_offer_valid", choice_valid, 0);
        chk("rst_mid_offer_choice", choice, 0);
        tick(5);
        chk("rst_idle_valid", choice_valid, 0);

        en = 1'b1;
        tick(2);
        sel_cnt = 0;
        sel_btn = 1'b1;
        first = 0;
        for (int n = 0; n < 60 && first == 0; n++) begin
            @(posedge clk);
            #1;
            if (sel_pulse) first = 1;
        end
        chk("hold_pulse_seen", first, 1);
        tick(200);
        sel_btn = 1'b0;
        tick(40);
`ifdef AUTO_REPEAT_EN
        exp_rep = 4;
`else
        exp_rep = 1;
`endif
        chk("hold_pulse_count", sel_cnt, exp_rep);
        chk("hold_choice", choice, exp_rep % 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1);
    end
endmodule
